// File: rtl/ycc_mcu_scheduler.sv
// ycc_mcu_scheduler
//   Reorders a raster RGB pixel stream into 8x8 block (MCU) order for the
//   RGB-to-YCbCr converter. Each 8-line strip is captured into one bank of a
//   two-bank line memory. The bank is drained as IMG_W/8 blocks, and each
//   block is a 64-cycle out_de burst issued on a downstream grant.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   frame_start           pulse that arms a new frame (ignored while busy)
//   in_valid/in_ready     source handshake; in_r/in_g/in_b pixel data
//   dst_ready             downstream can take one full 64-pixel block
//   out_r/out_g/out_b     block-ordered pixel data (held while out_de=0)
//   out_de, blk_start     pixel valid / first pixel of a block
//   frame_done            pulse in the cycle after the last pixel of the frame
//   busy                  frame in progress
//   err_sof               sticky: frame_start seen while busy
module ycc_mcu_scheduler #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_r,
    input  logic [7:0] in_g,
    input  logic [7:0] in_b,
    input  logic       dst_ready,
    output logic [7:0] out_r,
    output logic [7:0] out_g,
    output logic [7:0] out_b,
    output logic       out_de,
    output logic       blk_start,
    output logic       frame_done,
    output logic       busy,
    output logic       err_sof
);
    localparam int NBX = IMG_W / 8;
    localparam int NST = IMG_H / 8;
    localparam int BXW = (NBX > 1) ? $clog2(NBX) : 1;
    localparam int SW  = (NST > 1) ? $clog2(NST) : 1;
    // x is stored as {block column, column in block} so reads need no adder
    localparam int XW  = BXW + 3;
    localparam int AW  = XW + 4;
    localparam logic [XW-1:0]  X_LAST  = XW'(IMG_W - 1);
    localparam logic [BXW-1:0] BX_LAST = BXW'(NBX - 1);
    localparam logic [SW-1:0]  S_LAST  = SW'(NST - 1);

    typedef enum logic {W_IDLE, W_FILL} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BLOCK} rstate_t;

    wstate_t w_state_q, w_state_d;
    rstate_t r_state_q, r_state_d;

    logic [XW-1:0]  x_q, x_d;
    logic [2:0]     line_q, line_d;
    logic [SW-1:0]  wstrip_q, wstrip_d;
    logic           wb_q, wb_d;
    logic [1:0]     full_q, full_d;
    logic           in_ready_q, in_ready_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;
    logic [5:0]     c_q, c_d;
    logic [BXW-1:0] bx_q, bx_d;
    logic [SW-1:0]  rstrip_q, rstrip_d;
    logic           rb_q, rb_d;
    logic           de_p1_q, first_p1_q, last_p1_q, last_p2_q;
    logic           out_de_q, blk_start_q, frame_done_q;
    logic [23:0]    pix_q, rdata_q;
    logic [23:0]    mem [0:(1<<AW)-1];

    logic           start_ok, wr_en, wr_bank_done, wr_frame_done;
    logic           rd_en, rd_blk_end, rd_bank_done, rd_frame_last;
    logic [AW-1:0]  wr_addr, rd_addr;

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (start_ok) w_state_d = W_FILL;
            W_FILL:  if (wr_frame_done) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (full_q[rb_q]) r_state_d = R_WAIT;
            R_WAIT:  if (dst_ready) r_state_d = R_BLOCK;
            R_BLOCK: if (rd_blk_end) r_state_d = rd_bank_done ? R_IDLE : R_WAIT;
            default: r_state_d = R_IDLE;
        endcase
    end

    // FSM outputs: memory strobes, addresses and completion events
    always_comb begin
        start_ok      = frame_start && !busy_q;
        wr_en         = (w_state_q == W_FILL) && in_valid && in_ready_q;
        wr_bank_done  = wr_en && (line_q == 3'd7) && (x_q == X_LAST);
        wr_frame_done = wr_bank_done && (wstrip_q == S_LAST);
        rd_en         = (r_state_q == R_BLOCK);
        rd_blk_end    = rd_en && (c_q == 6'd63);
        rd_bank_done  = rd_blk_end && (bx_q == BX_LAST);
        rd_frame_last = rd_bank_done && (rstrip_q == S_LAST);
        wr_addr       = {wb_q, line_q, x_q};
        rd_addr       = {rb_q, c_q[5:3], bx_q, c_q[2:0]};
    end

    // Counters, bank pointers and full flags
    always_comb begin
        x_d      = x_q;
        line_d   = line_q;
        wstrip_d = wstrip_q;
        wb_d     = wb_q;
        full_d   = full_q;
        c_d      = c_q;
        bx_d     = bx_q;
        rstrip_d = rstrip_q;
        rb_d     = rb_q;
        busy_d   = busy_q;
        err_d    = err_q | (frame_start & busy_q);

        if (wr_en) begin
            if (x_q == X_LAST) begin
                x_d    = '0;
                line_d = line_q + 3'd1;
            end else begin
                x_d = x_q + XW'(1);
            end
            if (wr_bank_done) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
                wstrip_d     = wr_frame_done ? '0 : wstrip_q + SW'(1);
            end
        end

        if ((r_state_q == R_WAIT) && dst_ready) c_d = '0;
        if (rd_en) begin
            c_d = c_q + 6'd1;
            if (rd_blk_end) begin
                if (rd_bank_done) begin
                    bx_d         = '0;
                    full_d[rb_q] = 1'b0;
                    rb_d         = ~rb_q;
                    rstrip_d     = rd_frame_last ? '0 : rstrip_q + SW'(1);
                end else begin
                    bx_d = bx_q + BXW'(1);
                end
            end
        end

        if (last_p2_q) busy_d = 1'b0;

        // An odd strip count leaves both pointers on bank 1 at frame end;
        // realign both sides to bank 0 so the new frame starts consistently.
        if (start_ok) begin
            x_d      = '0;
            line_d   = '0;
            wstrip_d = '0;
            wb_d     = 1'b0;
            rb_d     = 1'b0;
            bx_d     = '0;
            rstrip_d = '0;
            full_d   = '0;
            busy_d   = 1'b1;
        end
    end

    // Registered from next-state values so a freed bank is writable next cycle
    assign in_ready_d = (w_state_d == W_FILL) && !full_d[wb_d];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q          <= '0;
            line_q       <= '0;
            wstrip_q     <= '0;
            wb_q         <= 1'b0;
            full_q       <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            c_q          <= '0;
            bx_q         <= '0;
            rstrip_q     <= '0;
            rb_q         <= 1'b0;
            de_p1_q      <= 1'b0;
            first_p1_q   <= 1'b0;
            last_p1_q    <= 1'b0;
            last_p2_q    <= 1'b0;
            out_de_q     <= 1'b0;
            blk_start_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pix_q        <= '0;
        end else begin
            x_q          <= x_d;
            line_q       <= line_d;
            wstrip_q     <= wstrip_d;
            wb_q         <= wb_d;
            full_q       <= full_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            c_q          <= c_d;
            bx_q         <= bx_d;
            rstrip_q     <= rstrip_d;
            rb_q         <= rb_d;
            // Stage 1 tracks the memory read, stage 2 is the output register
            de_p1_q      <= rd_en;
            first_p1_q   <= rd_en && (c_q == 6'd0);
            last_p1_q    <= rd_frame_last;
            out_de_q     <= de_p1_q;
            blk_start_q  <= first_p1_q;
            last_p2_q    <= last_p1_q;
            frame_done_q <= last_p2_q;
            if (de_p1_q) pix_q <= rdata_q;
        end
    end

    // Line memory: one write port, one synchronous read port
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= {in_r, in_g, in_b};
        rdata_q <= mem[rd_addr];
    end

    assign in_ready   = in_ready_q;
    assign out_r      = pix_q[23:16];
    assign out_g      = pix_q[15:8];
    assign out_b      = pix_q[7:0];
    assign out_de     = out_de_q;
    assign blk_start  = blk_start_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign err_sof    = err_q;
endmodule

// File: tb/tb_ycc_mcu_scheduler.sv
// Testbench for ycc_mcu_scheduler (IMG_W=16, IMG_H=24: 3 strips, 6 blocks).
// The reference model is the source image itself; the expected output
// stream is the image read out in strip / block-column / row / column order.
module tb_ycc_mcu_scheduler;
    localparam int W = 16;
    localparam int H = 24;
    localparam int TOTAL = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       in_valid = 1'b0;
    logic       dst_ready = 1'b0;
    logic [7:0] in_r = '0, in_g = '0, in_b = '0;
    logic       in_ready, out_de, blk_start, frame_done, busy, err_sof;
    logic [7:0] out_r, out_g, out_b;

    int errors = 0;
    int checks = 0;

    logic [23:0] img [H][W];
    logic [23:0] exp_q [$];
    int   n_acc = 0, npix = 0, nfd = 0, run = 0;
    bit   prev_de = 1'b0, mon_en = 1'b0, abort = 1'b0, overlap = 1'b0;
    logic [2:0] ir_hist = '0, ir_snap = '0;

    ycc_mcu_scheduler #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_g(in_g), .in_b(in_b), .dst_ready(dst_ready),
        .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_de(out_de),
        .blk_start(blk_start), .frame_done(frame_done), .busy(busy),
        .err_sof(err_sof)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Build the image and the expected block-ordered stream
    task automatic prep(input bit formula);
        logic [7:0] rv;
        exp_q.delete();
        npix = 0; nfd = 0; n_acc = 0; overlap = 1'b0; ir_snap = '0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                rv = 8'(y * 16 + x);
                if (formula) img[y][x] = {rv, 8'(x), 8'(y)};
                else         img[y][x] = 24'($urandom);
            end
        for (int s = 0; s < H / 8; s++)
            for (int bx = 0; bx < W / 8; bx++)
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++)
                        exp_q.push_back(img[s * 8 + r][bx * 8 + c]);
    endtask

    // Pulse frame_start with in_valid high: that cycle must not transfer
    task automatic pulse_start();
        frame_start = 1'b1; in_valid = 1'b1;
        {in_r, in_g, in_b} = img[0][0];
        @(posedge clk); #1;
        frame_start = 1'b0; in_valid = 1'b0;
        check("busy_set", busy, 1);
    endtask

    task automatic send_all(input int gap);
        int g;
        bit acc;
        for (int y = 0; y < H && !abort; y++)
            for (int x = 0; x < W && !abort; x++) begin
                if (gap > 0 && $urandom_range(0, 99) < gap) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
                {in_r, in_g, in_b} = img[y][x];
                in_valid = 1'b1;
                g = 0; acc = 1'b0;
                while (!acc && !abort && g < 3000) begin
                    acc = in_ready;
                    @(posedge clk); #1;
                    g++;
                end
                if (acc) n_acc++;
                else if (!abort) begin
                    check("pixel_accepted", acc, 1);
                    abort = 1'b1;
                end
            end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (nfd == 0 && g < 5000) begin @(posedge clk); #2; g++; end
        repeat (4) @(posedge clk);
        #2;
        check("frame_done_count", nfd, 1);
        check("exp_remaining", exp_q.size(), 0);
        check("pixels_out", npix, TOTAL);
        check("busy_after", busy, 0);
    endtask

    // Output stream monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_de = 1'b0; run = 0; ir_hist = '0;
        end else begin
            ir_hist = {ir_hist[1:0], in_ready};
            if (out_de === 1'b1) begin
                check("blk_start", blk_start, run == 0);
                check("pix_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("pixel", {out_r, out_g, out_b}, exp_q.pop_front());
                if (in_valid && in_ready) overlap = 1'b1;
                run++; npix++;
                if (npix == 128) ir_snap = ir_hist;
            end else begin
                if (prev_de) check("burst_len", run, 64);
                run = 0;
            end
            if (frame_done === 1'b1) begin
                nfd++;
                check("fd_after_last", {prev_de, out_de, npix == TOTAL}, 3'b101);
                check("busy_at_done", busy, 0);
            end
            prev_de = out_de;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_ctrl", {out_de, blk_start, frame_done, busy, err_sof, in_ready}, 0);
        check("rst_data", {out_r, out_g, out_b}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 0);
        mon_en = 1'b1;

        // Basic order, dst_ready held high
        prep(1'b1); dst_ready = 1'b1;
        pulse_start();
        send_all(0);
        wait_done();

        // Latency: grant 10 cycles after the first bank fills
        prep(1'b0); dst_ready = 1'b0;
        pulse_start();
        fork
            send_all(25);
            begin
                g = 0;
                while (n_acc < 128 && g < 3000) begin @(posedge clk); #2; g++; end
                check("lat_bank_full", n_acc >= 128, 1);
                repeat (10) @(posedge clk);
                #2;
                check("lat_pre", out_de, 0);
                dst_ready = 1'b1;
                @(posedge clk); #1;
                check("lat_e0", out_de, 0);
                @(posedge clk); #1;
                check("lat_e1", out_de, 0);
                @(posedge clk); #1;
                check("lat_e2", {out_de, blk_start}, 2'b11);
            end
        join
        wait_done();

        // Backpressure: both banks fill, then drain
        prep(1'b0); dst_ready = 1'b0;
        pulse_start();
        fork
            send_all(0);
            begin
                g = 0;
                while (n_acc < 256 && g < 3000) begin @(posedge clk); #2; g++; end
                repeat (5) @(posedge clk);
                #2;
                check("bp_stall_ready", in_ready, 0);
                check("bp_stall_count", n_acc, 256);
                check("bp_no_output", npix, 0);
                dst_ready = 1'b1;
                g = 0;
                while (npix < 128 && g < 3000) begin @(posedge clk); #2; g++; end
                check("bp_resume", ir_snap, 3'b011);
            end
        join
        wait_done();

        // Streaming overlap
        prep(1'b0); dst_ready = 1'b1;
        pulse_start();
        send_all(0);
        wait_done();
        check("overlap", overlap, 1);

        // Protocol error: frame_start mid-frame
        prep(1'b0); dst_ready = 1'b1;
        check("err_clear", err_sof, 0);
        pulse_start();
        fork
            send_all(10);
            begin
                g = 0;
                while (n_acc < 100 && g < 3000) begin @(posedge clk); #2; g++; end
                frame_start = 1'b1;
                @(posedge clk); #2;
                frame_start = 1'b0;
                check("err_set", err_sof, 1);
            end
        join
        wait_done();
        check("err_sticky", err_sof, 1);

        // Reset in the middle of a block
        prep(1'b0); dst_ready = 1'b1;
        pulse_start();
        fork
            send_all(0);
            begin
                g = 0;
                while (run < 30 && g < 3000) begin @(posedge clk); #2; g++; end
                check("rst_mid_reached", run, 30);
                abort = 1'b1;
                mon_en = 1'b0;
                rst_n = 1'b0;
                #1;
                check("rstmid_ctrl", {out_de, blk_start, frame_done, busy, err_sof, in_ready}, 0);
                check("rstmid_data", {out_r, out_g, out_b}, 0);
            end
        join
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rstmid_in_ready", in_ready, 0);
        abort = 1'b0;
        mon_en = 1'b1;
        prep(1'b1);
        pulse_start();
        send_all(0);
        wait_done();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
